// File: rtl/poly_sample_uniform.sv
// poly_sample_uniform
//   Rejection sampler that turns a stream of 16-bit little-endian SHAKE
//   words into N uniform coefficients below BOUND and writes them, in
//   ascending address order, to a polynomial RAM.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   en         global enable; low freezes state and the RAM address/data
//   start      begin sampling one polynomial (sampled only in HOLD)
//   done       one-cycle pulse, coincident with the write of coefficient N-1
//   din_valid  upstream word valid
//   din        16-bit candidate coefficient
//   din_ready  combinational; the block consumes din this cycle
//   ram_we     registered RAM write enable
//   ram_addr   registered RAM write address
//   ram_dout   registered RAM write data (candidate passed through unreduced)
module poly_sample_uniform #(
  parameter logic [15:0] Q     = 16'd12289,
  parameter logic [15:0] BOUND = 16'd61445,
  parameter logic [9:0]  N     = 10'd512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  output logic        done,
  input  logic        din_valid,
  input  logic [15:0] din,
  output logic        din_ready,
  output logic        ram_we,
  output logic [8:0]  ram_addr,
  output logic [15:0] ram_dout
);

  // A threshold below the modulus could never yield the full residue range.
  if (BOUND < Q) begin : g_bound_chk
    $error("poly_sample_uniform: BOUND must not be below Q");
  end

  typedef enum logic {HOLD, SAMPLE} state_t;

  typedef struct packed {
    logic        we;
    logic        done;
    logic [8:0]  addr;
    logic [15:0] data;
  } wr_t;

  state_t     state;
  logic [9:0] coeff_count;
  wr_t        wr_q;

  logic xfer;
  logic accept;
  logic last;

  assign din_ready = (state == SAMPLE) & en & (coeff_count < N);
  assign xfer      = din_valid & din_ready;
  assign accept    = xfer & (din < BOUND);
  assign last      = (coeff_count == N - 10'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      coeff_count <= '0;
      wr_q        <= '0;
    end else if (!en) begin
      // Stall: nothing is consumed, so no write or done may appear; address
      // and data keep their last values.
      wr_q.we   <= 1'b0;
      wr_q.done <= 1'b0;
    end else begin
      wr_q.we   <= 1'b0;
      wr_q.done <= 1'b0;
      unique case (state)
        HOLD: begin
          if (start) begin
            state       <= SAMPLE;
            coeff_count <= '0;
          end
        end
        SAMPLE: begin
          // start is deliberately not looked at here.
          if (accept) begin
            wr_q.we     <= 1'b1;
            wr_q.addr   <= coeff_count[8:0];
            wr_q.data   <= din;
            coeff_count <= coeff_count + 10'd1;
            if (last) begin
              wr_q.done <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

  assign ram_we   = wr_q.we;
  assign done     = wr_q.done;
  assign ram_addr = wr_q.addr;
  assign ram_dout = wr_q.data;

endmodule
